// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard.
//   tcode_t / TCODE_UNUSED : T_use/T_new code type; all-ones marks an unused operand
//   stage_e                : post-decode stage index names (0 = E, 1 = M, 2 = W)
//   FWD_RF / fwd_code()    : forward-select encoding (0 = register file, k+1 = stage k)
//   STALL_CNT_MAX          : saturation value of the stall-cycle counter
package hazard_scoreboard_pkg;

  typedef logic [2:0] tcode_t;
  localparam tcode_t TCODE_UNUSED = '1;

  typedef enum int unsigned {
    STG_E = 0,
    STG_M = 1,
    STG_W = 2
  } stage_e;

  localparam int FWD_RF = 0;

  // Forward-select code that picks the result held in post-decode stage k.
  function automatic int fwd_code(input int stage);
    return stage + 1;
  endfunction

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface.
//   master : the decoder; drives the D-stage instruction description and ext_stall
//   slave  : the scoreboard; returns stall, forward selects and the stall count
// d_src/d_tuse/d_fwd/e_fwd are packed per source, source s at [s*W +: W].
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int TW      = 3,
  parameter int SELW    = 2
);

  logic                   d_valid;
  logic [NUM_SRC*AW-1:0]  d_src;
  logic [NUM_SRC*TW-1:0]  d_tuse;
  logic                   d_wr_en;
  logic [AW-1:0]          d_wr_addr;
  logic [TW-1:0]          d_tnew;
  logic                   ext_stall;
  logic                   stall;
  logic [NUM_SRC*SELW-1:0] d_fwd;
  logic [NUM_SRC*SELW-1:0] e_fwd;
  logic [31:0]            stall_cnt;

  modport master (
    output d_valid, d_src, d_tuse, d_wr_en, d_wr_addr, d_tnew, ext_stall,
    input  stall, d_fwd, e_fwd, stall_cnt
  );

  modport slave (
    input  d_valid, d_src, d_tuse, d_wr_en, d_wr_addr, d_tnew, ext_stall,
    output stall, d_fwd, e_fwd, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: youngest-match priority finder over the in-flight write entries.
//   addr      : register being looked up (register 0 never matches)
//   ent_*     : entry array, index 0 = youngest (E)
//   hit       : some entry in LO..N-1 matches
//   index     : lowest matching entry index
//   tnew      : that entry's remaining T_new
// LO lets the E-stage consumer skip entry 0, which is its own instruction.
module hazard_match #(
  parameter int N  = 3,
  parameter int AW = 5,
  parameter int TW = 3,
  parameter int LO = 0,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [AW-1:0] addr,
  input  logic          ent_valid [N],
  input  logic [AW-1:0] ent_addr  [N],
  input  logic [TW-1:0] ent_tnew  [N],
  output logic          hit,
  output logic [IW-1:0] index,
  output logic [TW-1:0] tnew
);

  // NOTE: every output gets a default before the loop so no path through the
  // block leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    tnew  = '0;
    // Scan oldest to youngest; the last hit written is the youngest one.
    for (int k = N - 1; k >= LO; k--) begin
      if (ent_valid[k] && addr != '0 && ent_addr[k] == addr) begin
        hit   = 1'b1;
        index = IW'(k);
        tnew  = ent_tnew[k];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit for the pipelined MIPS core.
//   clk, reset : clock; asynchronous active-high reset
//   bus.slave  : D-stage instruction (valid, sources, T_use, write enable/addr,
//                T_new), ext_stall in; stall, d_fwd, e_fwd, stall_cnt out
// Entry k tracks the register write of the instruction in post-decode stage k;
// tnew counts cycles until that result exists, relative to the current cycle.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int TW         = $bits(tcode_t),
  parameter int SELW       = 2
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // In-flight write entries, index 0 = E.
  logic          ent_valid [NUM_STAGES];
  logic [AW-1:0] ent_addr  [NUM_STAGES];
  logic [TW-1:0] ent_tnew  [NUM_STAGES];

  // Sources of the instruction currently in E.
  logic          e_src_valid [NUM_SRC];
  logic [AW-1:0] e_src_addr  [NUM_SRC];

  logic          d_hit  [NUM_SRC];
  logic [IW-1:0] d_idx  [NUM_SRC];
  logic [TW-1:0] d_tnm  [NUM_SRC];
  logic          e_hit  [NUM_SRC];
  logic [IW-1:0] e_idx  [NUM_SRC];
  logic [TW-1:0] e_tnm  [NUM_SRC];

  logic [NUM_SRC-1:0]      hazard;
  logic [NUM_SRC*SELW-1:0] d_fwd_v;
  logic [NUM_SRC*SELW-1:0] e_fwd_v;
  logic                    stall;
  logic [31:0]             stall_cnt_q;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_match #(.N(NUM_STAGES), .AW(AW), .TW(TW), .LO(0), .IW(IW)) u_d_match (
      .addr      (bus.d_src[s*AW +: AW]),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr),
      .ent_tnew  (ent_tnew),
      .hit       (d_hit[s]),
      .index     (d_idx[s]),
      .tnew      (d_tnm[s])
    );

    hazard_match #(.N(NUM_STAGES), .AW(AW), .TW(TW), .LO(int'(STG_M)), .IW(IW)) u_e_match (
      .addr      (e_src_addr[s]),
      .ent_valid (ent_valid),
      .ent_addr  (ent_addr),
      .ent_tnew  (ent_tnew),
      .hit       (e_hit[s]),
      .index     (e_idx[s]),
      .tnew      (e_tnm[s])
    );

    // By the time an instruction reaches E, every older write it depends on
    // must already have its result, otherwise the D-stage stall let it through early.
    always_ff @(posedge clk) begin
      if (!reset) begin
        assert (!(e_src_valid[s] && e_hit[s] && e_tnm[s] != '0));
      end
    end
  end

  always_comb begin
    hazard  = '0;
    d_fwd_v = '0;
    e_fwd_v = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      // An all-ones T_use means the operand is not read at all.
      if (!(&bus.d_tuse[s*TW +: TW]) && d_hit[s] && d_tnm[s] > bus.d_tuse[s*TW +: TW]) begin
        hazard[s] = 1'b1;
      end
      d_fwd_v[s*SELW +: SELW] = (d_hit[s] && d_tnm[s] == '0) ?
                                SELW'(fwd_code(int'(d_idx[s]))) : SELW'(FWD_RF);
      e_fwd_v[s*SELW +: SELW] = (e_src_valid[s] && e_hit[s] && e_tnm[s] == '0) ?
                                SELW'(fwd_code(int'(e_idx[s]))) : SELW'(FWD_RF);
    end
  end

  assign stall         = (|hazard) | bus.ext_stall;
  assign bus.stall     = stall;
  assign bus.d_fwd     = d_fwd_v;
  assign bus.e_fwd     = e_fwd_v;
  assign bus.stall_cnt = stall_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the entry shift register shift.
  // The entry array is only NUM_STAGES flops deep, so it is fully reset rather
  // than treated as an unreset memory; valid alone would not clear stale tnew.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        ent_valid[k] <= 1'b0;
        ent_addr[k]  <= '0;
        ent_tnew[k]  <= '0;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        e_src_valid[s] <= 1'b0;
        e_src_addr[s]  <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_addr[k]  <= ent_addr[k-1];
        ent_tnew[k]  <= sat_dec(ent_tnew[k-1]);
      end

      // A stalled D instruction stays put and E receives a bubble.
      if (!stall && bus.d_valid && bus.d_wr_en && bus.d_wr_addr != '0) begin
        ent_valid[0] <= 1'b1;
        ent_addr[0]  <= bus.d_wr_addr;
        ent_tnew[0]  <= sat_dec(bus.d_tnew);
      end else begin
        ent_valid[0] <= 1'b0;
        ent_addr[0]  <= '0;
        ent_tnew[0]  <= '0;
      end

      for (int s = 0; s < NUM_SRC; s++) begin
        if (!stall) begin
          e_src_valid[s] <= bus.d_valid && !(&bus.d_tuse[s*TW +: TW]);
          e_src_addr[s]  <= bus.d_src[s*AW +: AW];
        end else begin
          e_src_valid[s] <= 1'b0;
          e_src_addr[s]  <= '0;
        end
      end

      if (stall && stall_cnt_q != STALL_CNT_MAX) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations are queued when a D-stage
// instruction is driven and checked at the following falling edge.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int { SIG_STALL, SIG_DFWD, SIG_EFWD, SIG_CNT } sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] NU = TCODE_UNUSED;

  function automatic logic [31:0] fv(input int s0, input int s1);
    logic [1:0] a;
    logic [1:0] b;
    a = 2'(s0);
    b = 2'(s1);
    return {28'b0, b, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [2:0] tu_rs,
                       input logic [4:0] rt, input logic [2:0] tu_rt,
                       input logic we, input logic [4:0] wa, input logic [2:0] tn);
    bus.d_valid   = v;
    bus.d_src     = {rt, rs};
    bus.d_tuse    = {tu_rt, tu_rs};
    bus.d_wr_en   = we;
    bus.d_wr_addr = wa;
    bus.d_tnew    = tn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, NU, 5'd0, NU, 1'b0, 5'd0, 3'd0);
  endtask

  task automatic expect_sig(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then move
  // to just after the next rising edge for the next drive.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        SIG_STALL: check(e.tag, {31'b0, bus.stall}, e.val);
        SIG_DFWD:  check(e.tag, {28'b0, bus.d_fwd}, e.val);
        SIG_EFWD:  check(e.tag, {28'b0, bus.e_fwd}, e.val);
        default:   check(e.tag, bus.stall_cnt, e.val);
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.ext_stall = 1'b0;
    idle();
    #1;
    expect_sig("rst_stall", SIG_STALL, 32'd0);
    expect_sig("rst_dfwd",  SIG_DFWD,  32'd0);
    expect_sig("rst_efwd",  SIG_EFWD,  32'd0);
    expect_sig("rst_cnt",   SIG_CNT,   32'd0);
    cyc();
    reset = 1'b0;

    // lw $1 (tnew 3) -> add $2,$1,$1 (tuse 1)
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd1, 3'd3);
    expect_sig("lw_issue_stall", SIG_STALL, 32'd0);
    cyc();
    drive(1'b1, 5'd1, 3'd1, 5'd1, 3'd1, 1'b1, 5'd2, 3'd2);
    expect_sig("lw_add_stall", SIG_STALL, 32'd1);
    expect_sig("lw_add_cnt0",  SIG_CNT,   32'd0);
    cyc();
    expect_sig("lw_add_go",    SIG_STALL, 32'd0);
    expect_sig("lw_add_dfwd",  SIG_DFWD,  fv(0, 0));
    cyc();
    idle();
    expect_sig("lw_add_efwd",  SIG_EFWD,  fv(fwd_code(STG_W), fwd_code(STG_W)));
    expect_sig("lw_add_cnt1",  SIG_CNT,   32'd1);
    cyc();
    expect_sig("lw_add_ebub",  SIG_EFWD,  fv(0, 0));
    cyc();
    flush(2);

    // ori $1 (tnew 2) -> beq $1,$0 (tuse 0)
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd1, 3'd2);
    cyc();
    drive(1'b1, 5'd1, 3'd0, 5'd0, 3'd0, 1'b0, 5'd0, 3'd0);
    expect_sig("ori_beq_stall", SIG_STALL, 32'd1);
    cyc();
    expect_sig("ori_beq_go",    SIG_STALL, 32'd0);
    expect_sig("ori_beq_dfwd",  SIG_DFWD,  fv(fwd_code(STG_M), 0));
    cyc();
    idle();
    expect_sig("ori_beq_efwd",  SIG_EFWD,  fv(fwd_code(STG_W), 0));
    expect_sig("ori_beq_cnt",   SIG_CNT,   32'd2);
    cyc();
    flush(3);

    // add $3 -> sub $3 -> sw $3 (Rt tuse 2): younger sub wins
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd3, 3'd2);
    cyc();
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd3, 3'd2);
    expect_sig("sub_stall", SIG_STALL, 32'd0);
    cyc();
    drive(1'b1, 5'd0, 3'd1, 5'd3, 3'd2, 1'b0, 5'd0, 3'd0);
    expect_sig("sw_stall",  SIG_STALL, 32'd0);
    expect_sig("sw_dfwd",   SIG_DFWD,  fv(0, 0));
    cyc();
    idle();
    expect_sig("sw_efwd",   SIG_EFWD,  fv(0, fwd_code(STG_M)));
    cyc();
    flush(3);

    // jal (tnew 0, $31) -> jr $31 (tuse 0)
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd31, 3'd0);
    cyc();
    drive(1'b1, 5'd31, 3'd0, 5'd0, NU, 1'b0, 5'd0, 3'd0);
    expect_sig("jr_stall", SIG_STALL, 32'd0);
    expect_sig("jr_dfwd",  SIG_DFWD,  fv(fwd_code(STG_E), 0));
    cyc();
    idle();
    expect_sig("jr_efwd",  SIG_EFWD,  fv(fwd_code(STG_M), 0));
    cyc();
    flush(3);

    // ext_stall coinciding with a data hazard counts once
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd8, 3'd3);
    cyc();
    drive(1'b1, 5'd8, 3'd1, 5'd0, NU, 1'b1, 5'd9, 3'd2);
    bus.ext_stall = 1'b1;
    expect_sig("both_stall", SIG_STALL, 32'd1);
    cyc();
    bus.ext_stall = 1'b0;
    expect_sig("both_go",    SIG_STALL, 32'd0);
    expect_sig("both_cnt",   SIG_CNT,   32'd3);
    cyc();
    flush(4);

    // ext_stall for 4 cycles: jal moves on while bubbles enter E behind it
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd31, 3'd0);
    cyc();
    drive(1'b1, 5'd31, 3'd0, 5'd0, NU, 1'b0, 5'd0, 3'd0);
    bus.ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_sig($sformatf("ext_stall_%0d", i), SIG_STALL, 32'd1);
      expect_sig($sformatf("ext_cnt_%0d", i),   SIG_CNT,   32'(3 + i));
      expect_sig($sformatf("ext_dfwd_%0d", i),  SIG_DFWD,  fv((i < 3) ? fwd_code(i) : 0, 0));
      expect_sig($sformatf("ext_efwd_%0d", i),  SIG_EFWD,  fv(0, 0));
      cyc();
    end
    bus.ext_stall = 1'b0;
    expect_sig("ext_release", SIG_STALL, 32'd0);
    expect_sig("ext_cnt_end", SIG_CNT,   32'd7);
    cyc();
    flush(3);

    // Saturation of stall_cnt from a preloaded value
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    bus.ext_stall = 1'b1;
    expect_sig("sat_0", SIG_CNT, 32'hFFFF_FFFD);
    cyc();
    expect_sig("sat_1", SIG_CNT, 32'hFFFF_FFFE);
    cyc();
    expect_sig("sat_2", SIG_CNT, 32'hFFFF_FFFF);
    cyc();
    bus.ext_stall = 1'b0;
    expect_sig("sat_hold", SIG_CNT, 32'hFFFF_FFFF);
    cyc();
    flush(3);

    // Reset asserted mid-stall after lw $1
    drive(1'b1, 5'd0, NU, 5'd0, NU, 1'b1, 5'd1, 3'd3);
    cyc();
    drive(1'b1, 5'd1, 3'd1, 5'd1, 3'd1, 1'b1, 5'd2, 3'd2);
    expect_sig("mid_stall", SIG_STALL, 32'd1);
    cyc();
    #1;
    reset = 1'b1;
    expect_sig("mid_rst_stall", SIG_STALL, 32'd0);
    expect_sig("mid_rst_dfwd",  SIG_DFWD,  fv(0, 0));
    expect_sig("mid_rst_cnt",   SIG_CNT,   32'd0);
    cyc();
    reset = 1'b0;
    expect_sig("post_rst_stall", SIG_STALL, 32'd0);
    expect_sig("post_rst_dfwd",  SIG_DFWD,  fv(0, 0));
    cyc();
    idle();
    expect_sig("post_rst_efwd", SIG_EFWD, fv(0, 0));
    expect_sig("post_rst_cnt",  SIG_CNT,  32'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined MIPS core; sits beside the decode stage.
- Consumes the per-instruction Rs/Rt T_use and T_new codes the decoder emits (3'b111 = operand unused).
- Tracks in-flight register writes across NUM_STAGES post-decode stages, generates the D-stage stall, and generates forward selects for the D-stage and E-stage consumers.
- Generalises the fixed E/M/W, two-operand scheme to configurable depth and source count, and adds an external stall input and a stall-cycle counter.

Parameters:
- NUM_STAGES, 3, in-flight stages after D (index 0 = E, 1 = M, 2 = W).
- NUM_SRC, 2, source operands per instruction (0 = Rs, 1 = Rt).
- AW, 5, register address width.
- TW, 3, T_use/T_new width; all-ones = unused.
- SELW, 2, forward-select width; must be at least clog2(NUM_STAGES+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- d_valid  in  1  D holds a real instruction
- d_src  in  NUM_SRC*AW  source register addresses, packed
- d_tuse  in  NUM_SRC*TW  T_use per source
- d_wr_en  in  1  instruction writes the register file
- d_wr_addr  in  AW  destination register
- d_tnew  in  TW  T_new at decode
- ext_stall  in  1  external stall request, e.g. multiply/divide busy
- stall  out  1  hold PC and the F/D register; insert a bubble into E
- d_fwd  out  NUM_SRC*SELW  D-stage forward select per source
- e_fwd  out  NUM_SRC*SELW  E-stage forward select per source
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Entry k holds {valid, addr, tnew}. tnew = cycles until the result exists, measured from the current cycle.
- Register X matches entry k when valid and addr == X. Register 0 never matches; writes to register 0 are never recorded.
- Stall:
  - For each source s with tuse != all-ones, take the youngest matching entry (lowest k).
  - Hazard if that entry's tnew > tuse[s].
  - stall = any hazard OR ext_stall. Purely combinational; no added latency.
- d_fwd[s]: k+1 when the youngest match has tnew == 0, else 0 (register file, which is write-through internally). Never depends on older matches when a younger one exists.
- E-source register:
  - On a non-stall edge, latches d_src and tuse validity (a source counts only when d_valid is set and its tuse is not all-ones).
  - On a stall edge, cleared to a bubble.
- e_fwd[s]: k+1 for the youngest match in entries 1..NUM_STAGES-1 with tnew == 0, else 0. A youngest match with tnew > 0 is unreachable by construction; assert it in simulation.
- Every edge, entries shift:
  - entry[k] <= entry[k-1] with tnew decremented, saturating at 0.
  - Entry 0 on a non-stall edge:
    - d_valid & d_wr_en & d_wr_addr != 0: valid=1, addr=d_wr_addr, tnew=sat(d_tnew-1).
    - Otherwise: bubble (valid=0).
  - Entry 0 on a stall edge: bubble.
  - The oldest entry drops off.
- stall_cnt increments on each edge with stall=1 and holds at 32'hFFFFFFFF.
- Reset (asynchronous, active-high, effective at any time including mid-stall):
  - All entries invalid, tnew=0.
  - E-source register cleared.
  - stall_cnt=0.
  - stall, d_fwd and e_fwd read 0 while reset is asserted, provided ext_stall=0.
- Simultaneous events:
  - ext_stall together with a data hazard gives one stall (one count).
  - Two in-flight writes to the same register: the younger always wins.

Decomposition:
- Shared package/constants file: the TW all-ones "unused" code, forward-select encodings (0 = RF, k+1 = stage k), and stage index names E/M/W.
- One sub-module, hazard_match: a combinational youngest-match priority finder over the entries. Inputs: address, entry array. Outputs: hit, index, tnew. Instantiated once per source per consumer (D, E).

Test Plan:
- lw $1 (tnew 3) then add $2,$1,$1 (tuse 1) -> stall=1 for 1 cycle, then 0 with d_fwd=0. Next cycle e_fwd=3 (W, lw reached W). stall_cnt=1.
- ori $1 (tnew 2) then beq $1,$0 (tuse 0) -> stall=1 for 1 cycle, then d_fwd[0]=2 (M). No stall on the Rt source, since $0 never matches.
- add $3 then sub $3 then sw $3 (Rt tuse 2) -> no stall. sw's Rt selects the younger sub: e_fwd[1]=2 at sw in E, never 3.
- jal (tnew 0, wr 31) then jr $31 (tuse 0) -> stall=0, d_fwd[0]=1 (E).
- ext_stall=1 for 4 cycles with no data hazards -> stall=1 for 4 cycles, 4 bubbles enter E, stall_cnt=4. Preload stall_cnt near 32'hFFFFFFFF and verify it saturates.
- Assert reset mid-stall after lw $1 -> entries cleared immediately, stall=0. A following add $2,$1,$1 after reset release gets no stall and d_fwd=0.
